// File: rtl/imem_prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_prog_loader_pkg;

    // Loader control states
    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDone,
        StErr
    } state_e;

    // Default end-of-program marker, zero-extended to the memory word width
    localparam logic [31:0] EndWordDefault = 32'h0000_0FFF;

    // Width of a source-select field; never narrower than one bit
    function automatic int unsigned sel_width(input int unsigned num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/imem_prog_loader_byte_packer.sv
// Packs an MSB-first byte stream into DATA_WIDTH words.
// word_o/word_valid_o are combinational: valid in the cycle the last byte is presented.
module byte_packer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  dv_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_valid_o
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]      idx_q;

    assign word_o       = (shift_q << 8) | DATA_WIDTH'(byte_i);
    assign word_valid_o = dv_i && (idx_q == IDX_W'(BYTES - 1));

    // Shift accepted bytes in and track position within the current word
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (dv_i) begin
            shift_q <= word_o;
            idx_q   <= word_valid_o ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_prog_loader.sv
// Instruction-memory program loader: selects one of NUM_SRC byte streams, packs
// bytes into words and writes them from address 0 until the end marker arrives.
// Optional checksum word after the end marker: define IMEM_PROG_LOADER_CHECKSUM_EN.
module imem_prog_loader
    import imem_prog_loader_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ADDR_WIDTH = 12,
    parameter int unsigned            NUM_SRC    = 2,
    parameter logic [DATA_WIDTH-1:0]  END_WORD   = DATA_WIDTH'(EndWordDefault),
    localparam int unsigned           SEL_W      = sel_width(NUM_SRC)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [SEL_W-1:0]      src_sel_i,
    input  logic [NUM_SRC-1:0]    rx_dv_i,
    input  logic [NUM_SRC*8-1:0]  rx_byte_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  core_reset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic                  chk_err_o,
    output logic [ADDR_WIDTH:0]   word_count_o
);
    state_e                  state_q;
    logic [SEL_W-1:0]        sel_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH:0]     cnt_q;
    logic [ADDR_WIDTH:0]     cnt_eff;
    logic                    ovf_q;
    logic                    sel_ok;
    logic                    sel_dv;
    logic [7:0]              sel_byte;
    logic [DATA_WIDTH-1:0]   word;
    logic                    word_valid;
`ifdef IMEM_PROG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   sum_q;
    logic                    chk_phase_q;
    logic                    chk_err_q;
`endif

    assign sel_ok  = (32'(src_sel_i) < NUM_SRC);
    // Count including a write issued last cycle whose increment is still pending
    assign cnt_eff = cnt_q + (ADDR_WIDTH + 1)'(we_q);

    // Route the latched source's strobe and byte to the packer
    always_comb begin
        sel_dv   = 1'b0;
        sel_byte = 8'h00;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_dv   = rx_dv_i[k];
                sel_byte = rx_byte_i[8*k +: 8];
            end
        end
    end

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (state_q != StRecv),
        .dv_i         (sel_dv && (state_q == StRecv)),
        .byte_i       (sel_byte),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // Load FSM, write register, word counter and sticky status flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
`ifdef IMEM_PROG_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            chk_phase_q <= 1'b0;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            we_q  <= 1'b0;
            cnt_q <= cnt_eff;
            case (state_q)
                StRecv: begin
                    if (word_valid) begin
`ifdef IMEM_PROG_LOADER_CHECKSUM_EN
                        if (chk_phase_q) begin
                            if (word == sum_q) begin
                                state_q <= StDone;
                            end else begin
                                chk_err_q <= 1'b1;
                                state_q   <= StErr;
                            end
                        end else
`endif
                        if (word == END_WORD) begin
`ifdef IMEM_PROG_LOADER_CHECKSUM_EN
                            chk_phase_q <= 1'b1;
`else
                            state_q <= StDone;
`endif
                        end else if (cnt_eff[ADDR_WIDTH]) begin
                            // DEPTH words already written
                            ovf_q   <= 1'b1;
                            state_q <= StErr;
                        end else begin
                            we_q    <= 1'b1;
                            addr_q  <= cnt_eff[ADDR_WIDTH-1:0];
                            wdata_q <= word;
`ifdef IMEM_PROG_LOADER_CHECKSUM_EN
                            sum_q   <= sum_q + word;
`endif
                        end
                    end
                end
                StIdle, StDone, StErr: begin
                    if (start_i) begin
                        sel_q       <= src_sel_i;
                        addr_q      <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
`ifdef IMEM_PROG_LOADER_CHECKSUM_EN
                        sum_q       <= '0;
                        chk_phase_q <= 1'b0;
                        chk_err_q   <= 1'b0;
`endif
                        state_q     <= sel_ok ? StRecv : StErr;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign we_o         = we_q;
    assign addr_o       = addr_q;
    assign wdata_o      = wdata_q;
    assign word_count_o = cnt_q;
    assign core_reset_o = (state_q == StRecv);
    assign busy_o       = (state_q == StRecv);
    assign done_o       = (state_q == StDone);
    assign overflow_o   = ovf_q;
`ifdef IMEM_PROG_LOADER_CHECKSUM_EN
    assign chk_err_o    = chk_err_q;
`else
    assign chk_err_o    = 1'b0;
`endif

endmodule
